// File: rtl/mage_cfg_shadow_regs.sv
// MAGE PEA config bank: bus writes land in a shadow copy, and a commit copies it atomically to the active outputs once the PEA is idle.
// Every request is answered one cycle later and nothing stalls; defining MAGE_CFG_READBACK_EN lets reads with the address MSB set return active-bank words.
module mage_cfg_shadow_regs #(
    parameter int N             = 4,
    parameter int M             = 4,
    parameter int N_CFG_REGS_PE = 2,
    parameter int N_DMA_CH      = 4,
    parameter int ADDR_W        = 12
) (
    input  logic                                        clk_i,
    input  logic                                        rst_n_i,
    input  logic                                        req_valid_i,
    input  logic                                        req_write_i,
    input  logic [ADDR_W-1:0]                           req_addr_i,
    input  logic [31:0]                                 req_wdata_i,
    output logic                                        rsp_valid_o,
    output logic [31:0]                                 rsp_rdata_o,
    output logic                                        rsp_error_o,
    input  logic                                        pea_idle_i,
    output logic                                        commit_done_o,
    output logic                                        active_valid_o,
    output logic [1:0]                                  reg_separate_cols_o,
    output logic [N_DMA_CH-1:0]                         reg_dma_ch_cfg_o,
    output logic [M-1:0][$clog2(N):0]                   reg_sel_out_col_pea_o,
    output logic [N-1:0][M-1:0][31:0]                   reg_acc_value_pe_o,
    output logic [N-1:0][M-1:0][31:0]                   reg_pea_constants_o,
    output logic [N-1:0][M-1:0][N_CFG_REGS_PE-1:0][31:0] reg_cfg_pea_o
);
    localparam int LOG_N   = $clog2(N);
    localparam int SW      = LOG_N + 1;
    localparam int NPE     = N * M;
    localparam int NCFG    = NPE * N_CFG_REGS_PE;
    localparam int SEL_B   = 4;
    localparam int ACC_B   = SEL_B + M;
    localparam int CONST_B = ACC_B + NPE;
    localparam int CFG_B   = CONST_B + NPE;
    localparam int N_WORDS = CFG_B + NCFG;

    logic                       r_pending, r_active_valid, r_commit_done;
    logic                       r_rsp_valid, r_rsp_error;
    logic [31:0]                r_rsp_rdata;
    logic [15:0]                r_commit_cnt;
    logic [1:0]                 r_sh_sep, r_act_sep;
    logic [N_DMA_CH-1:0]        r_sh_dma, r_act_dma;
    logic [M-1:0][SW-1:0]       r_sh_sel, r_act_sel;
    logic [NPE-1:0][31:0]       r_sh_acc, r_act_acc;
    logic [NPE-1:0][31:0]       r_sh_const, r_act_const;
    logic [NCFG-1:0][31:0]      r_sh_cfg, r_act_cfg;

    logic        w_mirror, w_in_data, w_is_ctrl, w_is_stat, w_is_data, w_mirror_ok;
    logic [31:0] w_idx, w_sh_val, w_rdata, w_status;
    logic        w_err, w_wr_data, w_ctrl_wr, w_commit;
    logic        w_unused_addr_bits;

`ifdef MAGE_CFG_READBACK_EN
    logic [31:0] w_act_val;
    assign w_mirror = req_addr_i[ADDR_W-1];
    assign w_idx    = w_mirror ? 32'(req_addr_i[ADDR_W-2:2]) : 32'(req_addr_i[ADDR_W-1:2]);
`else
    assign w_mirror = 1'b0;
    assign w_idx    = 32'(req_addr_i[ADDR_W-1:2]);
`endif
    assign w_unused_addr_bits = ^req_addr_i[1:0];

    assign w_in_data   = (w_idx >= 32'd2) && (w_idx < 32'(N_WORDS));
    assign w_is_ctrl   = !w_mirror && (w_idx == 32'd0);
    assign w_is_stat   = !w_mirror && (w_idx == 32'd1);
    assign w_is_data   = !w_mirror && w_in_data;
    assign w_mirror_ok = w_mirror && w_in_data;
    assign w_status    = {r_commit_cnt, 14'd0, r_active_valid, r_pending};
    assign w_commit    = r_pending && pea_idle_i;
    assign w_ctrl_wr   = req_valid_i && req_write_i && w_is_ctrl;
    assign w_wr_data   = req_valid_i && req_write_i && w_is_data && !r_pending;

    always_comb begin
        w_sh_val = '0;
        if (w_idx == 32'd2) w_sh_val = 32'(r_sh_sep);
        if (w_idx == 32'd3) w_sh_val = 32'(r_sh_dma);
        for (int i = 0; i < M; i++)    if (w_idx == 32'(SEL_B + i))   w_sh_val = 32'(r_sh_sel[i]);
        for (int i = 0; i < NPE; i++)  if (w_idx == 32'(ACC_B + i))   w_sh_val = r_sh_acc[i];
        for (int i = 0; i < NPE; i++)  if (w_idx == 32'(CONST_B + i)) w_sh_val = r_sh_const[i];
        for (int i = 0; i < NCFG; i++) if (w_idx == 32'(CFG_B + i))   w_sh_val = r_sh_cfg[i];
    end

`ifdef MAGE_CFG_READBACK_EN
    always_comb begin
        w_act_val = '0;
        if (w_idx == 32'd2) w_act_val = 32'(r_act_sep);
        if (w_idx == 32'd3) w_act_val = 32'(r_act_dma);
        for (int i = 0; i < M; i++)    if (w_idx == 32'(SEL_B + i))   w_act_val = 32'(r_act_sel[i]);
        for (int i = 0; i < NPE; i++)  if (w_idx == 32'(ACC_B + i))   w_act_val = r_act_acc[i];
        for (int i = 0; i < NPE; i++)  if (w_idx == 32'(CONST_B + i)) w_act_val = r_act_const[i];
        for (int i = 0; i < NCFG; i++) if (w_idx == 32'(CFG_B + i))   w_act_val = r_act_cfg[i];
    end
`endif

    // Writes are only legal to CTRL/STATUS or to the data region while no commit is pending.
    always_comb begin
        w_rdata = '0;
        if (req_write_i) begin
            w_err = !(w_is_ctrl || w_is_stat || (w_is_data && !r_pending));
        end else begin
            w_err = !(w_is_ctrl || w_is_stat || w_is_data || w_mirror_ok);
            if (w_is_stat)      w_rdata = w_status;
            else if (w_is_data) w_rdata = w_sh_val;
`ifdef MAGE_CFG_READBACK_EN
            else if (w_mirror_ok) w_rdata = w_act_val;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sh_sep   <= '0;
            r_sh_dma   <= '0;
            r_sh_sel   <= '0;
            r_sh_acc   <= '0;
            r_sh_const <= '0;
            r_sh_cfg   <= '0;
        end else if (w_wr_data) begin
            if (w_idx == 32'd2) r_sh_sep <= req_wdata_i[1:0];
            if (w_idx == 32'd3) r_sh_dma <= req_wdata_i[N_DMA_CH-1:0];
            for (int i = 0; i < M; i++)    if (w_idx == 32'(SEL_B + i))   r_sh_sel[i]   <= req_wdata_i[SW-1:0];
            for (int i = 0; i < NPE; i++)  if (w_idx == 32'(ACC_B + i))   r_sh_acc[i]   <= req_wdata_i;
            for (int i = 0; i < NPE; i++)  if (w_idx == 32'(CONST_B + i)) r_sh_const[i] <= req_wdata_i;
            for (int i = 0; i < NCFG; i++) if (w_idx == 32'(CFG_B + i))   r_sh_cfg[i]   <= req_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_act_sep   <= '0;
            r_act_dma   <= '0;
            r_act_sel   <= '0;
            r_act_acc   <= '0;
            r_act_const <= '0;
            r_act_cfg   <= '0;
        end else if (w_commit) begin
            r_act_sep   <= r_sh_sep;
            r_act_dma   <= r_sh_dma;
            r_act_sel   <= r_sh_sel;
            r_act_acc   <= r_sh_acc;
            r_act_const <= r_sh_const;
            r_act_cfg   <= r_sh_cfg;
        end
    end

    // A CTRL write landing on the commit edge re-arms pending; abort beats set.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pending      <= 1'b0;
            r_active_valid <= 1'b0;
            r_commit_done  <= 1'b0;
            r_commit_cnt   <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_error    <= 1'b0;
            r_rsp_rdata    <= '0;
        end else begin
            if (w_ctrl_wr && req_wdata_i[1])      r_pending <= 1'b0;
            else if (w_ctrl_wr && req_wdata_i[0]) r_pending <= 1'b1;
            else if (w_commit)                    r_pending <= 1'b0;
            r_commit_done <= w_commit;
            if (w_commit) begin
                r_active_valid <= 1'b1;
                r_commit_cnt   <= r_commit_cnt + 16'd1;
            end
            r_rsp_valid <= req_valid_i;
            r_rsp_error <= req_valid_i && w_err;
            r_rsp_rdata <= req_valid_i ? w_rdata : 32'd0;
        end
    end

    assign rsp_valid_o           = r_rsp_valid;
    assign rsp_rdata_o           = r_rsp_rdata;
    assign rsp_error_o           = r_rsp_error;
    assign commit_done_o         = r_commit_done;
    assign active_valid_o        = r_active_valid;
    assign reg_separate_cols_o   = r_act_sep;
    assign reg_dma_ch_cfg_o      = r_act_dma;
    assign reg_sel_out_col_pea_o = r_act_sel;
    assign reg_acc_value_pe_o    = r_act_acc;
    assign reg_pea_constants_o   = r_act_const;
    assign reg_cfg_pea_o         = r_act_cfg;
endmodule

// File: tb/tb_mage_cfg_shadow_regs.sv
// Directed + randomized bench for mage_cfg_shadow_regs against a word-array model of shadow/active banks.
module tb_mage_cfg_shadow_regs;
    localparam int N = 4, M = 4, K = 2, NDMA = 4, ADDR_W = 12;
    localparam int LOG_N   = $clog2(N);
    localparam int SW      = LOG_N + 1;
    localparam int SEL_MAX = (1 << SW) - 1;
    localparam int NPE     = N * M;
    localparam int ACC_B   = 4 + M;
    localparam int CONST_B = ACC_B + NPE;
    localparam int CFG_B   = CONST_B + NPE;
    localparam int NW      = CFG_B + NPE * K;

    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_write = 1'b0, pea_idle = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic rsp_valid, rsp_error, commit_done, active_valid;
    logic [31:0] rsp_rdata;
    logic [1:0] sep_o;
    logic [NDMA-1:0] dma_o;
    logic [M-1:0][LOG_N:0] sel_o;
    logic [N-1:0][M-1:0][31:0] acc_o, cst_o;
    logic [N-1:0][M-1:0][K-1:0][31:0] cfg_o;

    mage_cfg_shadow_regs #(.N(N), .M(M), .N_CFG_REGS_PE(K), .N_DMA_CH(NDMA), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error),
        .pea_idle_i(pea_idle), .commit_done_o(commit_done), .active_valid_o(active_valid),
        .reg_separate_cols_o(sep_o), .reg_dma_ch_cfg_o(dma_o), .reg_sel_out_col_pea_o(sel_o),
        .reg_acc_value_pe_o(acc_o), .reg_pea_constants_o(cst_o), .reg_cfg_pea_o(cfg_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model: one 32-bit word per map entry, banks as plain arrays.
    logic [31:0] sh [NW];
    logic [31:0] act[NW];
    bit pend, aval;
    logic [15:0] cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wmask(input int unsigned idx);
        if (idx == 2) return 32'h3;
        if (idx == 3) return 32'((1 << NDMA) - 1);
        if (idx >= 4 && idx < ACC_B) return 32'(SEL_MAX);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin sh[i] = '0; act[i] = '0; end
        pend = 0; aval = 0; cnt = '0;
    endtask

    task automatic check_active();
        chk("act_sep", 32'(sep_o), act[2]);
        chk("act_dma", 32'(dma_o), act[3]);
        for (int c = 0; c < M; c++) chk("act_sel", 32'(sel_o[c]), act[4 + c]);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < M; c++) begin
                chk("act_acc", acc_o[r][c], act[ACC_B + r * M + c]);
                chk("act_const", cst_o[r][c], act[CONST_B + r * M + c]);
                for (int k = 0; k < K; k++)
                    chk("act_cfg", cfg_o[r][c][k], act[CFG_B + (r * M + c) * K + k]);
            end
    endtask

    // One clock: drive a request, predict from pre-edge model state, then update and compare.
    task automatic cycle(input bit v, input bit w, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                         input bit idle, output logic [31:0] rd_o, output logic er_o);
        bit commit_now, mir, is_data, do_wr, do_ctrl;
        int unsigned idx;
        logic [31:0] exp_rd;
        bit exp_err;
        req_valid = v; req_write = w; req_addr = a; req_wdata = d; pea_idle = idle;
        commit_now = pend && idle;
        mir = 0;
`ifdef MAGE_CFG_READBACK_EN
        mir = a[ADDR_W-1];
        idx = mir ? int'(a[ADDR_W-2:2]) : int'(a[ADDR_W-1:2]);
`else
        idx = int'(a[ADDR_W-1:2]);
`endif
        is_data = (idx >= 2) && (idx < NW);
        exp_rd = '0; exp_err = 0; do_wr = 0; do_ctrl = 0;
        if (!w) begin
            if (mir) begin
                exp_err = !is_data;
                if (is_data) exp_rd = act[idx];
            end else if (idx == 0) exp_rd = '0;
            else if (idx == 1) exp_rd = {cnt, 14'd0, aval, pend};
            else if (is_data) exp_rd = sh[idx];
            else exp_err = 1;
        end else begin
            if (mir) exp_err = 1;
            else if (idx == 0) do_ctrl = v;
            else if (idx == 1) exp_err = 0;
            else if (is_data) begin
                if (pend) exp_err = 1; else do_wr = v;
            end else exp_err = 1;
        end
        @(posedge clk);
        #1;
        if (commit_now) begin
            for (int i = 0; i < NW; i++) act[i] = sh[i];
            aval = 1;
            cnt = cnt + 16'd1;
        end
        if (do_wr) sh[idx] = d & wmask(idx);
        if (do_ctrl && d[1]) pend = 0;
        else if (do_ctrl && d[0]) pend = 1;
        else if (commit_now) pend = 0;
        chk("rsp_valid", 32'(rsp_valid), 32'(v));
        chk("rsp_rdata", rsp_rdata, v ? exp_rd : 32'd0);
        chk("rsp_error", 32'(rsp_error), 32'(v && exp_err));
        chk("commit_done", 32'(commit_done), 32'(commit_now));
        chk("active_valid", 32'(active_valid), 32'(aval));
        rd_o = rsp_rdata; er_o = rsp_error;
        req_valid = 0;
    endtask

    logic [31:0] rdv;
    logic erv;
    task automatic wr(input int idx, input logic [31:0] d, input bit idle);
        cycle(1, 1, ADDR_W'(idx * 4), d, idle, rdv, erv);
    endtask
    task automatic rd(input int idx, input bit idle);
        cycle(1, 0, ADDR_W'(idx * 4), 32'd0, idle, rdv, erv);
    endtask
    task automatic nop(input bit idle);
        cycle(0, 0, '0, 32'd0, idle, rdv, erv);
    endtask

    int unsigned op, ridx, guard;
    bit ridle;
    logic [31:0] rdat;

    initial begin
        model_reset();
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_active_valid", 32'(active_valid), 32'd0);
        chk("rst_commit_done", 32'(commit_done), 32'd0);
        check_active();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Shadow write is visible to reads but not to active outputs.
        wr(CONST_B + 5, 32'hDEAD_BEEF, 1);
        rd(CONST_B + 5, 1);
        chk("const5_read", rdv, 32'hDEAD_BEEF);
        chk("const5_active", cst_o[1][1], 32'd0);

        rd(NW, 1);
        chk("oor_err", 32'(erv), 32'd1);
        chk("oor_rdata", rdv, 32'd0);
        wr(4, 32'hFFFF_FFFF, 1);
        rd(4, 1);
        chk("sel0_trunc", rdv, 32'(SEL_MAX));

        // Commit held off by a busy PEA; data writes rejected while pending.
        wr(0, 32'h1, 0);
        wr(ACC_B, 32'h1111_2222, 0);
        chk("acc_while_pending_err", 32'(erv), 32'd1);
        nop(0);
        chk("no_done_while_busy", 32'(commit_done), 32'd0);
        nop(1);
        chk("done_after_idle", 32'(commit_done), 32'd1);
        rd(1, 1);
        chk("status_after_commit", rdv, 32'h0001_0002);
        check_active();

        wr(0, 32'h3, 1);
        nop(1);
        chk("set_abort_no_done", 32'(commit_done), 32'd0);
        rd(1, 1);
        chk("status_after_abort", rdv, 32'h0001_0002);

        // Idle PEA: commit lands one cycle after the CTRL write.
        wr(ACC_B + 7, 32'h0BAD_F00D, 1);
        wr(0, 32'h1, 1);
        chk("not_yet_applied", acc_o[1][3], 32'd0);
        nop(1);
        chk("applied_next_cycle", acc_o[1][3], 32'h0BAD_F00D);

        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            ridx = $urandom_range(0, NW + 3);
            ridle = ($urandom_range(0, 3) != 0);
            rdat = $urandom;
            if (op == 0) wr(0, 32'($urandom_range(0, 3)), ridle);
            else if (op == 1) nop(ridle);
`ifdef MAGE_CFG_READBACK_EN
            else if (op == 2)
                cycle(1, $urandom_range(0, 1) == 1, ADDR_W'(ridx * 4) | ADDR_W'(1 << (ADDR_W - 1)),
                      rdat, ridle, rdv, erv);
`endif
            else cycle(1, op[0], ADDR_W'(ridx * 4), rdat, ridle, rdv, erv);
            if (n % 50 == 49) check_active();
        end
        wr(0, 32'h2, 1);

`ifdef MAGE_CFG_READBACK_EN
        wr(CONST_B + 2, 32'h1234_5678, 1);
        wr(0, 32'h1, 1);
        nop(1);
        wr(CONST_B + 2, 32'hCAFE_0001, 1);
        cycle(1, 0, ADDR_W'((CONST_B + 2) * 4) | ADDR_W'(1 << (ADDR_W - 1)), 32'd0, 1, rdv, erv);
        chk("mirror_read", rdv, 32'h1234_5678);
        cycle(1, 1, ADDR_W'((CONST_B + 2) * 4) | ADDR_W'(1 << (ADDR_W - 1)), 32'h5, 1, rdv, erv);
        chk("mirror_write_err", 32'(erv), 32'd1);
`endif

        // Back-to-back CTRL writes commit every cycle up to the count wrap.
        guard = 0;
        while (cnt != 16'hFFFF && guard < 70000) begin
            wr(0, 32'h1, 1);
            guard++;
        end
        rd(1, 1);
        chk("status_ffff", rdv, 32'hFFFF_0003);
        rd(1, 1);
        chk("status_wrapped", rdv, 32'h0000_0002);
        chk("wrap_active_valid", 32'(active_valid), 32'd1);
        check_active();

        // Reset while pending and mid-response.
        wr(0, 32'h1, 0);
        rd(1, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_drop_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_active_valid2", 32'(active_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_active();
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd(1, 1);
        chk("status_after_reset", rdv, 32'd0);
        nop(1);
        chk("no_commit_after_reset", 32'(commit_done), 32'd0);
        check_active();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mage_cfg_shadow_regs.md
MAGE_CFG_SHADOW_REGS -- requirements
Module: mage_cfg_shadow_regs

Interface
REQ-001 SHALL have parameter N, default 4: PEA rows.
REQ-002 SHALL have parameter M, default 4: PEA columns.
REQ-003 SHALL have parameter N_CFG_REGS_PE, default 2: config words per PE.
REQ-004 SHALL have parameter N_DMA_CH, default 4: streaming DMA channels.
REQ-005 SHALL have parameter ADDR_W, default 12: byte-address width.
REQ-006 SHALL have ports, in this order:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  bus request.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_W  byte address; word index = req_addr_i[ADDR_W-1:2].
- req_wdata_i  in  32  write data.
- rsp_valid_o  out  1  response strobe.
- rsp_rdata_o  out  32  read data.
- rsp_error_o  out  1  access error.
- pea_idle_i  in  1  PEA idle; commit allowed.
- commit_done_o  out  1  one-cycle pulse when the active bank is updated.
- active_valid_o  out  1  active bank holds a committed configuration.
- reg_separate_cols_o  out  2  active separate-columns field.
- reg_dma_ch_cfg_o  out  N_DMA_CH  active DMA channel configuration.
- reg_sel_out_col_pea_o  out  M x (LOG_N+1)  active per-column output select.
- reg_acc_value_pe_o  out  N x M x 32  active accumulator init values.
- reg_pea_constants_o  out  N x M x 32  active PE constants.
- reg_cfg_pea_o  out  N x M x N_CFG_REGS_PE x 32  active PE configuration words.

Function
REQ-007 SHALL decode the word map: 0 CTRL, 1 STATUS, 2 SEPARATE_COLS, 3 DMA_CH, then M SEL_OUT_COL words, then N*M ACC words, then N*M CONST words, then N*M*N_CFG_REGS_PE CFG words. Index order within each region is row-major, i.e. (row*M+col)*N_CFG_REGS_PE+k.
REQ-008 SHALL assert rsp_valid_o exactly one cycle after each accepted req_valid_i. rsp_rdata_o and rsp_error_o are valid only in that cycle; rsp_rdata_o is 0 otherwise.
REQ-009 Data-region writes SHALL update only the shadow bank. Fields narrower than 32 bits are truncated on write and zero-extended on read.
REQ-010 Data-region reads SHALL return shadow contents.
REQ-011 An address beyond the last CFG word SHALL produce rsp_error_o=1 and rdata 0. Such a write is discarded.
REQ-012 A CTRL write with bit0=1 SHALL set pending. While pending is set, data-region writes SHALL return rsp_error_o=1 and be discarded.
REQ-013 A CTRL write with bit1=1 SHALL clear pending. If bits 0 and 1 are written together, abort wins.
REQ-014 In the first cycle where pending=1 and pea_idle_i=1, the block SHALL copy the whole shadow bank to the active bank atomically. In that same cycle it SHALL clear pending, set active_valid_o, and pulse commit_done_o in the following cycle.
REQ-015 A commit request that arrives while pea_idle_i=1 SHALL apply exactly one cycle after the CTRL write. There SHALL be no combinational path from req_* to active outputs.
REQ-016 STATUS read SHALL return: bit0 pending, bit1 active_valid, bits[31:16] commit count. The commit count is 16 bits, increments per applied commit, and wraps 0xFFFF->0.
REQ-017 STATUS writes SHALL be ignored without error. A CTRL read SHALL return 0.
REQ-018 All active outputs SHALL be driven directly from active-bank flops.

Reset
REQ-019 On rst_n_i low, asynchronously, the block SHALL clear both banks, pending, active_valid_o, commit_done_o, rsp_valid_o, rsp_error_o and the commit count.
REQ-020 A reset mid-pending SHALL discard the commit. A reset asserted during a response cycle SHALL drop that response.

Configuration
REQ-021 Macro MAGE_CFG_READBACK_EN. When defined, a read with req_addr_i[ADDR_W-1]=1 SHALL return the active-bank value of the data-region word addressed by the remaining bits. Writes to that mirror SHALL return rsp_error_o=1. When undefined, such addresses are out of range per REQ-011.

Verification
REQ-022 Write CONST[5]=0xDEADBEEF, then read it -> rdata 0xDEADBEEF, and reg_pea_constants_o[1][1] stays 0.
REQ-023 Hold pea_idle_i=0, commit, write ACC[0], then raise idle -> ACC write returns error. commit_done_o pulses one cycle after idle rises, and STATUS reads 0x00010002.
REQ-024 With pea_idle_i=1, write CTRL=0x3 -> no commit, STATUS bit0=0, commit count unchanged.
REQ-025 Read a word index one past the last CFG word -> rsp_error_o=1, rdata 0. Write SEL_OUT_COL[0]=0xFFFFFFFF, then read it -> 2^(LOG_N+1)-1.
REQ-026 Preload commit count 0xFFFF via 65535 commits, then commit again -> count 0x0000, active_valid_o stays 1.
REQ-027 Assert reset while pending, then release -> all outputs 0 and pending 0. With MAGE_CFG_READBACK_EN defined, a mirror read after a commit -> returns the committed active value.
